psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Downstream consumer of the 8-lane signed dot-product stage. Each accepted beat carries that stage's two partial sums; the block adds the pair and accumulates over a run-time programmable number of vectors (len). It then presents one signed result through a valid/ready handshake to the next stage (requantizer or writeback).

## Interface
- IN_SIZE_0, 4: operand-0 width of the upstream dot-product stage
- IN_SIZE_1, 8: operand-1 width of the upstream dot-product stage
- LEN_W, 8: width of the vector-count input; at most 2^LEN_W-1 vectors per result
- PSUM_SIZE, IN_SIZE_0+IN_SIZE_1+8: width of each upstream partial sum
- ACC_SIZE, PSUM_SIZE+1+LEN_W: accumulator and result width; the default cannot overflow

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- psum_i  in  [0:1][PSUM_SIZE]  signed partial sums from the upstream stage
- psum_valid_i  in  1  psum_i valid (upstream fixed-latency delay of its input valid)
- psum_ready_o  out  1  block can accept a beat
- len_i  in  LEN_W  vectors per result; sampled only on the first beat of a run
- result_o  out  ACC_SIZE  signed accumulated result
- result_valid_o  out  1  result_o valid
- result_ready_i  in  1  downstream accepts the result
- result_sat_o  out  1  result was clamped (SATURATE_EN only)

## Operation
- Beat accepted when psum_valid_i && psum_ready_o at a rising clk_i edge.
- pair = sext(psum_i[0]) + sext(psum_i[1]), computed at PSUM_SIZE+1 bits, then sign-extended to ACC_SIZE.
- FSM states: IDLE, ACC, OUT.
- IDLE
  - psum_ready_o=1.
  - On a beat: acc<=pair, cnt<=1, len_q<=(len_i==0 ? 1 : len_i).
  - Next state is OUT if the effective len is 1, else ACC.
- ACC
  - psum_ready_o=1.
  - On a beat: acc<=acc+pair, cnt<=cnt+1.
  - Go to OUT when cnt+1==len_q.
  - Gaps in valid are allowed; state and acc are held.
- OUT
  - psum_ready_o=0, result_valid_o=1, result_o=acc.
  - On result_ready_i, go to IDLE and clear result_sat_o.
- Backpressure: result_o and result_sat_o stay stable while result_valid_o && !result_ready_i.
- Beats presented during OUT are not accepted; upstream must stall.
- Arithmetic is two's complement. Without SATURATE_EN, the accumulator wraps modulo 2^ACC_SIZE.

## Timing
- Reset values: state IDLE, acc=0, cnt=0, len_q=0.
- Output reset values: result_o=0, result_valid_o=0, result_sat_o=0, psum_ready_o=1.
- psum_ready_o = (state!=OUT). It is combinational from state only, with no path from result_ready_i.
- Latency: last beat accepted at edge k puts result_valid_o high in the cycle after edge k.
- Handshake completing at edge m makes psum_ready_o high in the cycle after m.
- Throughput: len beats per result, plus at least one bubble cycle in OUT.
- Reset mid-run discards the partial accumulation immediately (asynchronous). The next beat after release starts a fresh run.
- len_i changes during ACC are ignored.

## Configuration
- SATURATE_EN defined:
  - Each add is computed at ACC_SIZE+1 bits.
  - On overflow, acc is clamped to 2^(ACC_SIZE-1)-1 or -2^(ACC_SIZE-1), and the sticky result_sat_o is set for the current run.
  - Once clamped, acc stays clamped in that direction until an add brings it back in range.
- SATURATE_EN undefined:
  - Wrap-around arithmetic.
  - result_sat_o is tied to 0; the port still exists.

## Structure
- Shared package psum_acc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACC, OUT} psum_acc_state_t
  - default-width localparams derived from IN_SIZE_0/IN_SIZE_1
- One sub-module, psum_sat_add:
  - ACC_SIZE-wide signed adder with a sat flag output.
  - It contains the only SATURATE_EN ifdef.

## Test plan
- Defaults, len_i=1, psum_i={100,-30} -> result_o=70 one cycle after acceptance; psum_ready_o=0 until the handshake.
- len_i=255, every beat {4096,4096} (worst-case -8*-128*8 split) -> result_o=2088960, no wrap, result_sat_o=0.
- len_i=4 with valid gaps of 0/2/5 cycles, pairs {1,2},{-3,0},{10,-10},{7,7} -> result_o=14.
- result_ready_i held low 5 cycles in OUT -> result_o stable, psum_ready_o=0, offered beats not accepted; result_valid_o drops the cycle after ready.
- len_i=0 -> treated as 1. Reset asserted after 3 of 8 beats -> all outputs at reset values; the following len=1 run of {5,5} gives 10.
- ACC_SIZE=16, len_i=1, {20000,20000}: with SATURATE_EN -> 32767 and result_sat_o=1; without -> -25536 and result_sat_o=0.

Source files
------------

// File: rtl/psum_acc_pkg.sv
// Shared types and default widths for the partial-sum accumulator slice.
package psum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } psum_acc_state_t;

  localparam int DEF_IN_SIZE_0 = 4;
  localparam int DEF_IN_SIZE_1 = 8;
  localparam int DEF_LEN_W     = 8;
  localparam int DEF_PSUM_SIZE = DEF_IN_SIZE_0 + DEF_IN_SIZE_1 + 8;
  localparam int DEF_ACC_SIZE  = DEF_PSUM_SIZE + 1 + DEF_LEN_W;

endpackage

// File: rtl/psum_sat_add.sv
// Signed W-bit accumulator adder; clamps and flags overflow when SATURATE_EN is
// defined, otherwise wraps modulo 2^W with sat_o tied low.
module psum_sat_add #(
  parameter int W  = 29,
  parameter int BW = 21
) (
  input  logic signed [W-1:0]  a_i,
  input  logic signed [BW-1:0] b_i,
  output logic signed [W-1:0]  sum_o,
  output logic                 sat_o
);

  // Wide enough that neither operand nor their sum can overflow before clamping.
  localparam int EW = ((W > BW) ? W : BW) + 1;

  logic signed [EW-1:0] a_x;
  logic signed [EW-1:0] b_x;
  logic signed [EW-1:0] s_x;

  assign a_x = {{(EW-W){a_i[W-1]}}, a_i};
  assign b_x = {{(EW-BW){b_i[BW-1]}}, b_i};
  assign s_x = a_x + b_x;

`ifdef SATURATE_EN
  localparam logic signed [EW-1:0] MAXV = {{(EW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    sum_o = s_x[W-1:0];
    sat_o = 1'b0;
    if (s_x > MAXV) begin
      sum_o = MAXV[W-1:0];
      sat_o = 1'b1;
    end else if (s_x < MINV) begin
      sum_o = MINV[W-1:0];
      sat_o = 1'b1;
    end
  end
`else
  logic unused_hi;

  assign sum_o     = s_x[W-1:0];
  assign sat_o     = 1'b0;
  assign unused_hi = ^s_x[EW-1:W];
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates len pairs of upstream partial sums into one signed result with a
// valid/ready output handshake. Optional clamping via SATURATE_EN.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int IN_SIZE_0 = DEF_IN_SIZE_0,
  parameter int IN_SIZE_1 = DEF_IN_SIZE_1,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int PSUM_SIZE = IN_SIZE_0 + IN_SIZE_1 + 8,
  parameter int ACC_SIZE  = PSUM_SIZE + 1 + LEN_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [0:1][PSUM_SIZE-1:0]  psum_i,
  input  logic                       psum_valid_i,
  output logic                       psum_ready_o,
  input  logic [LEN_W-1:0]           len_i,
  output logic signed [ACC_SIZE-1:0] result_o,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic                       result_sat_o
);

  psum_acc_state_t state_q, state_d;

  logic signed [ACC_SIZE-1:0]  acc_q;
  logic [LEN_W-1:0]            cnt_q;
  logic [LEN_W-1:0]            len_q;
  logic                        sat_q;

  logic signed [PSUM_SIZE:0]   pair;
  logic signed [ACC_SIZE-1:0]  add_a;
  logic signed [ACC_SIZE-1:0]  add_sum;
  logic                        add_sat;
  logic [LEN_W-1:0]            len_eff;
  logic                        take;

  assign pair = {psum_i[0][PSUM_SIZE-1], psum_i[0]} +
                {psum_i[1][PSUM_SIZE-1], psum_i[1]};

  // First beat of a run adds onto zero so it passes through the same clamp.
  assign add_a   = (state_q == IDLE) ? '0 : acc_q;
  assign len_eff = (len_i == '0) ? LEN_W'(1) : len_i;
  assign take    = psum_valid_i && psum_ready_o;

  psum_sat_add #(
    .W  (ACC_SIZE),
    .BW (PSUM_SIZE + 1)
  ) u_add (
    .a_i   (add_a),
    .b_i   (pair),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    psum_ready_o   = (state_q != OUT);
    result_valid_o = (state_q == OUT);
    unique case (state_q)
      IDLE: if (take) state_d = (len_eff == LEN_W'(1)) ? OUT : ACC;
      ACC:  if (take && ((cnt_q + LEN_W'(1)) == len_q)) state_d = OUT;
      OUT:  if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else if (take) begin
      acc_q <= add_sum;
      if (state_q == IDLE) begin
        cnt_q <= LEN_W'(1);
        len_q <= len_eff;
        sat_q <= add_sat;
      end else begin
        cnt_q <= cnt_q + LEN_W'(1);
        sat_q <= sat_q | add_sat;
      end
    end else if ((state_q == OUT) && result_ready_i) begin
      sat_q <= 1'b0;
    end
  end

  assign result_o     = acc_q;
  assign result_sat_o = sat_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed plus randomized bench for psum_accumulator against an arithmetic
// reference model; honours SATURATE_EN when the build defines it.
module tb_psum_accumulator;

  localparam int PSUM  = 20;
  localparam int LW    = 8;
  localparam int ACC   = PSUM + 1 + LW;
  localparam int ACC16 = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [0:1][PSUM-1:0]    psum = '0;
  logic                    psum_valid = 1'b0;
  logic                    psum_ready;
  logic [LW-1:0]           len = '0;
  logic signed [ACC-1:0]   result;
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic                    res_sat;

  logic [0:1][PSUM-1:0]    b_psum = '0;
  logic                    b_valid = 1'b0;
  logic                    b_psum_ready;
  logic [LW-1:0]           b_len = '0;
  logic signed [ACC16-1:0] b_result;
  logic                    b_res_valid;
  logic                    b_res_ready = 1'b0;
  logic                    b_sat;

  int vectors = 0;
  int miscompares = 0;

  logic signed [PSUM-1:0] q0[$];
  logic signed [PSUM-1:0] q1[$];
  int                     gq[$];

  always #5 clk = ~clk;

  psum_accumulator #(.IN_SIZE_0(4), .IN_SIZE_1(8), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .psum_i(psum), .psum_valid_i(psum_valid),
    .psum_ready_o(psum_ready), .len_i(len), .result_o(result),
    .result_valid_o(res_valid), .result_ready_i(res_ready), .result_sat_o(res_sat)
  );

  psum_accumulator #(.IN_SIZE_0(4), .IN_SIZE_1(8), .LEN_W(LW), .ACC_SIZE(ACC16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .psum_i(b_psum), .psum_valid_i(b_valid),
    .psum_ready_o(b_psum_ready), .len_i(b_len), .result_o(b_result),
    .result_valid_o(b_res_valid), .result_ready_i(b_res_ready), .result_sat_o(b_sat)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sum of all queued pairs, clamped per add or wrapped to w bits.
  function automatic void model(input int w, output longint res, output bit sat);
    longint maxv = (longint'(1) <<< (w - 1)) - 1;
    longint minv = -(longint'(1) <<< (w - 1));
    longint m    = longint'(1) <<< w;
    longint acc  = 0;
    longint s;
    sat = 1'b0;
    for (int i = 0; i < q0.size(); i++) begin
      s = acc + longint'(q0[i]) + longint'(q1[i]);
`ifdef SATURATE_EN
      if (s > maxv) begin acc = maxv; sat = 1'b1; end
      else if (s < minv) begin acc = minv; sat = 1'b1; end
      else acc = s;
`else
      acc = ((s % m) + m) % m;
      if (acc > maxv) acc = acc - m;
`endif
    end
    res = acc;
  endfunction

  task automatic clear_q();
    q0.delete(); q1.delete(); gq.delete();
  endtask

  task automatic push(input int p0, input int p1, input int gap);
    q0.push_back(PSUM'(p0)); q1.push_back(PSUM'(p1)); gq.push_back(gap);
  endtask

  // Entered just after a negedge with the DUT idle.
  task automatic run(input string tag, input int len_val, input int stall);
    longint exp_r;
    bit     exp_s;
    model(ACC, exp_r, exp_s);
    for (int i = 0; i < q0.size(); i++) begin
      for (int g = 0; g < gq[i]; g++) begin
        psum_valid = 1'b0;
        @(negedge clk);
        check({tag, "_gap_valid"}, res_valid, 0);
        check({tag, "_gap_ready"}, psum_ready, 1);
      end
      psum_valid = 1'b1;
      psum[0]    = q0[i];
      psum[1]    = q1[i];
      len        = (i == 0) ? LW'(len_val) : LW'($urandom);
      @(negedge clk);
    end
    psum_valid = 1'b0;
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_sat"}, res_sat, exp_s);
    check({tag, "_ready_out"}, psum_ready, 0);
    for (int s = 0; s < stall; s++) begin
      psum_valid = 1'b1;
      psum[0]    = PSUM'($urandom);
      psum[1]    = PSUM'($urandom);
      @(negedge clk);
      check({tag, "_stall_result"}, result, exp_r);
      check({tag, "_stall_sat"}, res_sat, exp_s);
      check({tag, "_stall_ready"}, psum_ready, 0);
      check({tag, "_stall_valid"}, res_valid, 1);
    end
    psum_valid = 1'b0;
    res_ready  = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_post_valid"}, res_valid, 0);
    check({tag, "_post_ready"}, psum_ready, 1);
    check({tag, "_post_sat"}, res_sat, 0);
  endtask

  initial begin
    longint exp_r;
    bit     exp_s;

    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_valid", res_valid, 0);
    check("rst_sat", res_sat, 0);
    check("rst_ready", psum_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    clear_q(); push(100, -30, 0);
    run("len1", 1, 0);

    clear_q();
    for (int i = 0; i < 255; i++) push(4096, 4096, 0);
    run("len255", 255, 1);

    clear_q(); push(1, 2, 0); push(-3, 0, 2); push(10, -10, 5); push(7, 7, 0);
    run("gaps", 4, 0);

    clear_q(); push(-7, 3, 0); push(2, 2, 1);
    run("stall5", 2, 5);

    clear_q(); push(123, -456, 0);
    run("len0", 0, 2);

    // Asynchronous reset after 3 of 8 beats.
    psum_valid = 1'b1;
    len        = LW'(8);
    for (int i = 0; i < 3; i++) begin
      psum[0] = PSUM'(1000);
      psum[1] = PSUM'(2000);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", result, 0);
    check("midrst_valid", res_valid, 0);
    check("midrst_sat", res_sat, 0);
    check("midrst_ready", psum_ready, 1);
    psum_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_q(); push(5, 5, 0);
    run("after_rst", 1, 0);

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 12);
      clear_q();
      for (int i = 0; i < n; i++)
        push(int'($urandom), int'($urandom), $urandom_range(0, 3));
      run($sformatf("rnd%0d", r), (n == 1 && r[0]) ? 0 : n, $urandom_range(0, 4));
    end

    // Narrow-accumulator instance: one overflowing pair.
    clear_q(); push(20000, 20000, 0);
    model(ACC16, exp_r, exp_s);
    b_valid   = 1'b1;
    b_psum[0] = PSUM'(20000);
    b_psum[1] = PSUM'(20000);
    b_len     = LW'(1);
    @(negedge clk);
    b_valid = 1'b0;
    check("acc16_valid", b_res_valid, 1);
    check("acc16_result", b_result, exp_r);
    check("acc16_sat", b_sat, exp_s);
    b_res_ready = 1'b1;
    @(negedge clk);
    b_res_ready = 1'b0;
    check("acc16_post_valid", b_res_valid, 0);
    check("acc16_post_sat", b_sat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
